// File: rtl/fir_tap_sequencer_if.sv
// Bundle of the sample input, coefficient write, multiplier request/response and filter output signals.
// master = sequencer side, slave = surrounding logic (source, coefficient host, multiplier, sink).
interface fir_tap_sequencer_if #(
    parameter int DW    = 8,
    parameter int PW    = 16,
    parameter int ACC_W = 19,
    parameter int AW    = 3
);
    logic signed [DW-1:0]    x_in;
    logic                    x_valid;
    logic                    x_ready;
    logic                    coef_we;
    logic [AW-1:0]           coef_addr;
    logic signed [DW-1:0]    coef_wdata;
    logic                    mul_start;
    logic signed [DW-1:0]    mul_a;
    logic signed [DW-1:0]    mul_b;
    logic                    mul_done;
    logic signed [PW-1:0]    mul_product;
    logic signed [ACC_W-1:0] y_out;
    logic                    y_valid;
    logic                    y_ready;

    modport master (
        input  x_in, x_valid, coef_we, coef_addr, coef_wdata, mul_done, mul_product, y_ready,
        output x_ready, mul_start, mul_a, mul_b, y_out, y_valid
    );

    modport slave (
        output x_in, x_valid, coef_we, coef_addr, coef_wdata, mul_done, mul_product, y_ready,
        input  x_ready, mul_start, mul_a, mul_b, y_out, y_valid
    );
endinterface

// File: rtl/fir_tap_sequencer.sv
// FIR tap sequencer: one multiply per tap per accepted sample; y_valid TAPS*(1+Twl+Twh)+1 cycles after accept.
// Backpressure: x_ready low while computing or while the single held result waits for y_ready.
module fir_tap_sequencer #(
    parameter int TAPS  = 8,
    parameter int DW    = 8,
    parameter int PW    = 2 * DW,
    parameter int ACC_W = PW + $clog2(TAPS)
) (
    input  logic                clk,
    input  logic                rst,
    fir_tap_sequencer_if.master bus
);
    localparam int              AW       = $clog2(TAPS);
    localparam logic [AW:0]     TAPS_W   = (AW + 1)'(TAPS);
    localparam logic [AW-1:0]   LAST_TAP = AW'(TAPS - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_LO, WAIT_HI, OUT} state_t;

    state_t                  state_q, state_d;
    logic signed [DW-1:0]    d_q [TAPS];
    logic signed [DW-1:0]    c_q [TAPS];
    logic [AW-1:0]           tap_q;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] y_out_q;
    logic                    y_valid_q;

    logic                    x_ready_d;
    logic                    x_fire;
    logic                    coef_wr;
    logic                    prod_fire;
    logic                    last_tap;
    logic signed [ACC_W-1:0] prod_ext;
    logic                    mul_start_d;
    logic signed [DW-1:0]    mul_a_d;
    logic signed [DW-1:0]    mul_b_d;

    assign x_ready_d = (state_q == IDLE) && !y_valid_q;
    assign x_fire    = bus.x_valid && x_ready_d;
    assign coef_wr   = bus.coef_we && (state_q == IDLE) && ({1'b0, bus.coef_addr} < TAPS_W);
    assign prod_fire = (state_q == WAIT_HI) && bus.mul_done;
    assign last_tap  = (tap_q == LAST_TAP);
    assign prod_ext  = {{(ACC_W - PW){bus.mul_product[PW-1]}}, bus.mul_product};

    // Operands come straight from the banks: neither bank nor tap changes while busy, so they stay stable.
    always_comb begin
        state_d     = state_q;
        mul_start_d = 1'b0;
        mul_a_d     = '0;
        mul_b_d     = '0;
        unique case (state_q)
            IDLE: begin
                if (x_fire) state_d = ISSUE;
            end
            ISSUE: begin
                mul_start_d = 1'b1;
                mul_a_d     = c_q[tap_q];
                mul_b_d     = d_q[tap_q];
                state_d     = WAIT_LO;
            end
            WAIT_LO: begin
                mul_a_d = c_q[tap_q];
                mul_b_d = d_q[tap_q];
                if (!bus.mul_done) state_d = WAIT_HI;
            end
            WAIT_HI: begin
                mul_a_d = c_q[tap_q];
                mul_b_d = d_q[tap_q];
                if (bus.mul_done) state_d = last_tap ? OUT : ISSUE;
            end
            OUT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            tap_q     <= '0;
            acc_q     <= '0;
            y_out_q   <= '0;
            y_valid_q <= 1'b0;
            for (int k = 0; k < TAPS; k++) begin
                d_q[k] <= '0;
                c_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (coef_wr) c_q[bus.coef_addr] <= bus.coef_wdata;
            if (x_fire) begin
                d_q[0] <= bus.x_in;
                for (int k = 1; k < TAPS; k++) d_q[k] <= d_q[k-1];
                acc_q <= '0;
                tap_q <= '0;
            end
            if (prod_fire) begin
                acc_q <= acc_q + prod_ext;
                if (!last_tap) tap_q <= tap_q + AW'(1);
            end
            if (state_q == OUT) begin
                y_out_q   <= acc_q;
                y_valid_q <= 1'b1;
            end else if (y_valid_q && bus.y_ready) begin
                y_valid_q <= 1'b0;
            end
        end
    end

    assign bus.x_ready   = x_ready_d;
    assign bus.mul_start = mul_start_d;
    assign bus.mul_a     = mul_a_d;
    assign bus.mul_b     = mul_b_d;
    assign bus.y_out     = y_out_q;
    assign bus.y_valid   = y_valid_q;
endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Bench for fir_tap_sequencer: vector table, hand-written corner sequences and random samples
// checked against a sum-of-products model over a sample history and coefficient array.
module tb_fir_tap_sequencer;
    localparam int TAPS  = 8;
    localparam int DW    = 8;
    localparam int PW    = 16;
    localparam int ACC_W = 19;
    localparam int AW    = 3;
    localparam int BOUND = 500;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fir_tap_sequencer_if #(.DW(DW), .PW(PW), .ACC_W(ACC_W), .AW(AW)) bus ();

    fir_tap_sequencer #(.TAPS(TAPS), .DW(DW), .PW(PW), .ACC_W(ACC_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int starts = 0;
    int op_bad = 0;
    int mul_l = 4;
    int mul_drop = 1;
    int c_m [TAPS];
    int hist [TAPS];

    // Multiplier model: done falls mul_drop cycles and rises mul_l cycles after start.
    int                   age;
    bit                   mbusy;
    logic signed [DW-1:0] ma, mb;
    logic signed [PW-1:0] mprod;
    always @(negedge clk) begin
        if (bus.mul_start === 1'b1) starts++;
        if (rst) begin
            mbusy = 1'b0;
            bus.mul_done = 1'b0;
            bus.mul_product = '0;
        end else if (bus.mul_start) begin
            ma = bus.mul_a;
            mb = bus.mul_b;
            mprod = ma * mb;
            age = 0;
            mbusy = 1'b1;
        end else if (mbusy) begin
            age++;
            if (bus.mul_a !== ma || bus.mul_b !== mb) op_bad++;
            if (age == mul_drop) bus.mul_done = 1'b0;
            if (age == mul_l) begin
                bus.mul_done = 1'b1;
                bus.mul_product = mprod;
                mbusy = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: no response within %0d cycles, expected one", name, BOUND);
    endtask

    function automatic void clear_model();
        for (int k = 0; k < TAPS; k++) begin
            c_m[k] = 0;
            hist[k] = 0;
        end
    endfunction

    function automatic int model_y();
        int s = 0;
        for (int k = 0; k < TAPS; k++) s += c_m[k] * hist[k];
        return s;
    endfunction

    function automatic int cval(input int cset, input int k);
        case (cset)
            1:       return (k == 0) ? 1 : 0;
            2:       return k + 1;
            3:       return -128;
            default: return 0;
        endcase
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        bus.x_valid = 1'b0;
        bus.coef_we = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        clear_model();
    endtask

    task automatic write_coef(input int addr, input int val);
        bus.coef_we = 1'b1;
        bus.coef_addr = AW'(addr);
        bus.coef_wdata = DW'(val);
        @(negedge clk);
        bus.coef_we = 1'b0;
        c_m[addr] = val;
    endtask

    task automatic drive_x(input int x, input bit we, input int addr, input int val);
        int n = 0;
        bus.x_in = DW'(x);
        bus.x_valid = 1'b1;
        if (we) begin
            bus.coef_we = 1'b1;
            bus.coef_addr = AW'(addr);
            bus.coef_wdata = DW'(val);
        end
        while (bus.x_ready !== 1'b1 && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        if (n >= BOUND) fail_timeout("x_accept");
        @(negedge clk);
        bus.x_valid = 1'b0;
        bus.coef_we = 1'b0;
        if (we) c_m[addr] = val;
        for (int k = TAPS - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = x;
    endtask

    task automatic wait_y(output logic signed [ACC_W-1:0] y, output int lat);
        int n = 0;
        while (bus.y_valid !== 1'b1 && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        if (n >= BOUND) fail_timeout("y_valid");
        y = bus.y_out;
        lat = n;
    endtask

    task automatic run_sample(input string tag, input int x, output logic signed [ACC_W-1:0] y);
        int base, lat;
        base = starts;
        drive_x(x, 1'b0, 0, 0);
        wait_y(y, lat);
        chk({tag, "_y"}, y, model_y());
        chk({tag, "_starts"}, starts - base, TAPS);
        chk({tag, "_latency"}, lat, TAPS * (mul_l + 1) + 1);
    endtask

    typedef struct {
        bit rst_first;
        int cset;
        int x;
        int y_exp;
    } vec_t;
    vec_t vt [20];

    logic signed [ACC_W-1:0] y_got;
    int lat, base, n, yv_seen, y_exp_hold;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.x_in = '0;
        bus.x_valid = 1'b0;
        bus.coef_we = 1'b0;
        bus.coef_addr = '0;
        bus.coef_wdata = '0;
        bus.y_ready = 1'b1;
        do_reset();
        chk("rst_y_out", bus.y_out, 0);
        chk("rst_y_valid", bus.y_valid, 0);
        chk("rst_x_ready", bus.x_ready, 1);
        chk("rst_mul_start", bus.mul_start, 0);
        chk("rst_mul_a", bus.mul_a, 0);
        chk("rst_mul_b", bus.mul_b, 0);

        vt[0] = '{1, 1, 5, 5};
        vt[1] = '{0, 0, -3, -3};
        vt[2] = '{0, 0, 127, 127};
        vt[3] = '{1, 2, 1, 1};
        for (int i = 1; i < 8; i++) vt[3+i] = '{0, 0, 0, i + 1};
        for (int i = 0; i < 8; i++) vt[11+i] = '{(i == 0), (i == 0) ? 3 : 0, -128, 16384 * (i + 1)};
        vt[19] = '{1, 3, 127, -16256};

        for (int v = 0; v < 20; v++) begin
            if (vt[v].rst_first) do_reset();
            if (vt[v].cset != 0)
                for (int k = 0; k < TAPS; k++) write_coef(k, cval(vt[v].cset, k));
            run_sample("vec", vt[v].x, y_got);
            chk("vec_table_y", y_got, vt[v].y_exp);
        end

        // Backpressure: hold the result 20 cycles with a sample waiting, then release.
        do_reset();
        for (int k = 0; k < TAPS; k++) write_coef(k, cval(2, k));
        bus.y_ready = 1'b0;
        drive_x(10, 1'b0, 0, 0);
        wait_y(y_got, lat);
        y_exp_hold = model_y();
        chk("bp_y", y_got, y_exp_hold);
        bus.x_in = DW'(-7);
        bus.x_valid = 1'b1;
        base = starts;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", bus.y_valid, 1);
            chk("bp_hold_y", bus.y_out, y_exp_hold);
            chk("bp_hold_x_ready", bus.x_ready, 0);
        end
        chk("bp_no_issue", starts - base, 0);
        bus.y_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", bus.y_valid, 0);
        chk("bp_release_x_ready", bus.x_ready, 1);
        @(negedge clk);
        chk("bp_accept_next", bus.mul_start, 1);
        bus.x_valid = 1'b0;
        for (int k = TAPS - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = -7;
        wait_y(y_got, lat);
        chk("bp_next_y", y_got, model_y());
        chk("bp_next_latency", lat, TAPS * (mul_l + 1) + 1);

        // Stale done level held 3 cycles after start.
        mul_drop = 3;
        mul_l = 6;
        run_sample("stale", 77, y_got);
        run_sample("stale2", -45, y_got);
        mul_drop = 1;
        mul_l = 4;

        // Coefficient write in the same cycle as the sample handshake.
        @(negedge clk);
        drive_x(33, 1'b1, 0, -50);
        wait_y(y_got, lat);
        chk("same_cycle_coef_y", y_got, model_y());

        // Coefficient write while busy is dropped.
        drive_x(20, 1'b0, 0, 0);
        repeat (3) @(negedge clk);
        bus.coef_we = 1'b1;
        bus.coef_addr = AW'(2);
        bus.coef_wdata = DW'(99);
        @(negedge clk);
        bus.coef_we = 1'b0;
        wait_y(y_got, lat);
        chk("busy_write_y", y_got, model_y());
        run_sample("busy_write_after", 5, y_got);

        // Reset during tap 4.
        base = starts;
        drive_x(50, 1'b0, 0, 0);
        n = 0;
        while (starts - base < 5 && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        if (n >= BOUND) fail_timeout("tap4_issue");
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_y_valid", bus.y_valid, 0);
        chk("midrst_x_ready", bus.x_ready, 1);
        chk("midrst_mul_start", bus.mul_start, 0);
        chk("midrst_mul_a", bus.mul_a, 0);
        @(negedge clk);
        rst = 1'b0;
        clear_model();
        base = starts;
        yv_seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.y_valid !== 1'b0) yv_seen++;
        end
        chk("midrst_no_y_valid", yv_seen, 0);
        chk("midrst_no_issue", starts - base, 0);
        for (int k = 1; k < TAPS; k++) write_coef(k, 1);
        run_sample("midrst_zeroed", 9, y_got);
        chk("midrst_zero_history", y_got, 0);
        run_sample("midrst_followup", 3, y_got);

        // Random coefficients, samples and multiplier timing.
        for (int it = 0; it < 25; it++) begin
            mul_l = $urandom_range(2, 6);
            mul_drop = $urandom_range(1, mul_l - 1);
            n = $urandom_range(0, 3);
            for (int w = 0; w < n; w++)
                write_coef($urandom_range(0, TAPS - 1), int'($urandom_range(0, 255)) - 128);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_sample("rand", int'($urandom_range(0, 255)) - 128, y_got);
        end

        chk("operand_stability", op_bad, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
